macc_requant_8bit: RTL and testbench

//   Output end of the 8-bit MACC datapath: takes wide signed partial sums from the MACC/adder-tree stage,

---
 rtl/macc_requant_8bit.sv | 161 ++++++++++++++++
 tb/tb_macc_requant_8bit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/macc_requant_8bit.sv
// macc_requant_8bit
//   Output end of the 8-bit MACC datapath. Accumulates NUM_PASSES signed
//   partial sums per output pixel, adds bias, multiplies by an unsigned
//   scale, round-shifts (round half up), optionally applies ReLU and
//   saturates to signed int8. Three register stages after the final pass,
//   one input per cycle, no backpressure.
module macc_requant_8bit #(
    parameter int IN_WIDTH   = 21,
    parameter int NUM_PASSES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_WIDTH-1:0] i_data,
    input  logic                       i_valid,
    input  logic                       i_clear,
    input  logic signed [15:0]         i_bias,
    input  logic        [15:0]         i_scale,
    input  logic        [4:0]          i_shift,
    input  logic                       i_relu,
    output logic signed [7:0]          o_data,
    output logic                       o_valid
);

    localparam int ACC_WIDTH  = IN_WIDTH + $clog2(NUM_PASSES) + 1;
    localparam int PROD_WIDTH = ACC_WIDTH + 17;
    // One extra bit so the rounding increment can never wrap the product.
    localparam int RND_WIDTH  = PROD_WIDTH + 1;
    localparam int CNT_WIDTH  = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic signed [RND_WIDTH-1:0] SAT_MAX = RND_WIDTH'(127);
    localparam logic signed [RND_WIDTH-1:0] SAT_MIN = -RND_WIDTH'(128);

    // ------------------------------------------------------------------
    // Pass counter and accumulator
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]        cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        last_pass;
    logic                        accept;
    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] acc_term;

    assign last_pass = (cnt == CNT_WIDTH'(NUM_PASSES - 1));
    // Clear wins over a simultaneous valid: the beat is dropped entirely.
    assign accept    = i_valid && !i_clear;
    assign data_ext  = ACC_WIDTH'(i_data);
    assign bias_ext  = ACC_WIDTH'(i_bias);
    // With a single pass the accumulator never holds anything meaningful.
    assign acc_term  = (NUM_PASSES == 1) ? '0 : acc;

    // Count accepted passes and accumulate all but the final one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (i_clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (i_valid) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register in this block sees the pre-edge values of the others.
            if (last_pass) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
                acc <= (cnt == '0) ? data_ext : acc + data_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: S1 (sum + bias), S2 (scaled product), S3 (output)
    // ------------------------------------------------------------------
    logic                         s1_valid;
    logic signed [ACC_WIDTH-1:0]  s1_sum;
    logic [15:0]                  s1_scale;
    logic [4:0]                   s1_shift;
    logic                         s1_relu;

    logic                         s2_valid;
    logic signed [PROD_WIDTH-1:0] s2_prod;
    logic [4:0]                   s2_shift;
    logic                         s2_relu;

    // Valid bits are reset so no phantom output ever escapes after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept && last_pass;
            s2_valid <= s1_valid;
        end
    end

    // Datapath registers; their contents only matter when the matching valid is set.
    // NOTE: these have no reset on purpose -- the valid bits qualify them, and
    // leaving them unreset keeps reset fan-out off the wide datapath.
    always_ff @(posedge clk) begin
        if (accept && last_pass) begin
            s1_sum   <= acc_term + data_ext + bias_ext;
            s1_scale <= i_scale;
            s1_shift <= i_shift;
            s1_relu  <= i_relu;
        end
        s2_prod  <= PROD_WIDTH'(s1_sum) * PROD_WIDTH'($signed({1'b0, s1_scale}));
        s2_shift <= s1_shift;
        s2_relu  <= s1_relu;
    end

    // ------------------------------------------------------------------
    // Round, shift, ReLU, saturate
    // ------------------------------------------------------------------
    logic signed [RND_WIDTH-1:0] prod_ext;
    logic signed [RND_WIDTH-1:0] round_inc;
    logic signed [RND_WIDTH-1:0] shifted;
    logic signed [RND_WIDTH-1:0] clamped;
    logic signed [7:0]           sat_val;

    assign prod_ext = RND_WIDTH'(s2_prod);

    // Requantise the S2 product down to int8.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        round_inc = '0;
        shifted   = prod_ext;
        clamped   = '0;
        sat_val   = '0;

        if (s2_shift != 5'd0) begin
            round_inc = RND_WIDTH'(1) << (s2_shift - 5'd1);
            shifted   = (prod_ext + round_inc) >>> s2_shift;
        end

        clamped = (s2_relu && shifted[RND_WIDTH-1]) ? '0 : shifted;

        if (clamped > SAT_MAX) begin
            sat_val = 8'sd127;
        end else if (clamped < SAT_MIN) begin
            sat_val = -8'sd128;
        end else begin
            sat_val = clamped[7:0];
        end
    end

    // Output register: o_data holds its last value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_data <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_macc_requant_8bit.sv
// tb_macc_requant_8bit
//   Scoreboard bench: the driver pushes the reference result and its due
//   cycle when a final pass is accepted; a monitor pops and compares on
//   every o_valid pulse.
module tb_macc_requant_8bit;

    localparam int IN_W = 21;
    localparam int NP   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic signed [IN_W-1:0] i_data;
    logic                   i_valid;
    logic                   i_clear;
    logic signed [15:0]     i_bias;
    logic        [15:0]     i_scale;
    logic        [4:0]      i_shift;
    logic                   i_relu;
    logic signed [7:0]      o_data;
    logic                   o_valid;

    macc_requant_8bit #(.IN_WIDTH(IN_W), .NUM_PASSES(NP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_clear (i_clear),
        .i_bias  (i_bias),
        .i_scale (i_scale),
        .i_shift (i_shift),
        .i_relu  (i_relu),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    longint edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        longint val;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint last_out = 0;

    // Reference model state
    int     pidx = 0;
    longint psum = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requantisation straight from the arithmetic definition.
    function automatic longint ref_out(input longint sum, input int bias, input int scale,
                                       input int shift, input bit relu);
        longint p, num, d, q;
        p = (sum + bias) * scale;
        if (shift == 0) begin
            q = p;
        end else begin
            d   = 64'sd1 << shift;
            num = p + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0)) q = q - 1;  // floor division
        end
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Drive one cycle; inputs are applied #1 after an edge and sampled at the next.
    task automatic step(input bit v, input longint d, input bit clr,
                        input int bias = 0, input int scale = 1,
                        input int shift = 0, input bit relu = 0);
        i_valid = v;
        i_data  = d[IN_W-1:0];
        i_clear = clr;
        i_bias  = bias[15:0];
        i_scale = scale[15:0];
        i_shift = shift[4:0];
        i_relu  = relu;
        @(posedge clk);
        #1;
        if (clr) begin
            pidx = 0;
            psum = 0;
        end else if (v) begin
            psum += d;
            if (pidx == NP - 1) begin
                sb.push_back('{val: ref_out(psum, bias, scale, shift, relu), due: edge_cnt + 2});
                pidx = 0;
                psum = 0;
            end else begin
                pidx++;
            end
        end
    endtask

    task automatic group(input longint a, input longint b, input longint c, input longint d,
                         input int bias, input int scale, input int shift, input bit relu);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        step(1'b1, c, 1'b0);
        step(1'b1, d, 1'b0, bias, scale, shift, relu);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    // Monitor: compare every output pulse and the hold value between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            last_out = 0;
        end else if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_o_valid", 1, 0);
                last_out = o_data;
            end else begin
                e = sb.pop_front();
                check("o_data", o_data, e.val);
                check("latency_edge", edge_cnt, e.due);
                last_out = e.val;
            end
        end else begin
            if (o_valid !== 1'b0) check("o_valid_known", 1, 0);
            check("o_data_hold", o_data, last_out);
        end
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_clear = 1'b0;
        i_bias  = '0;
        i_scale = '0;
        i_shift = '0;
        i_relu  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_data", o_data, 0);
        rst_n = 1'b1;
        idle(2);

        // Directed cases
        group(100, 200, -50, 10, 0, 1, 0, 1'b0);   // 260 -> 127
        idle(4);
        group(5, 5, 5, 10, 0, 1, 1, 1'b0);         // 13
        group(-5, -5, -5, -10, 0, 1, 1, 1'b0);     // -12
        group(16, 16, 16, 16, -4, 3, 4, 1'b0);     // 11
        group(-75, -75, -75, -75, 0, 1, 0, 1'b1);  // 0
        group(-75, -75, -75, -75, 0, 1, 0, 1'b0);  // -128
        idle(3);

        // 16 back-to-back beats, distinct data
        for (int i = 0; i < 16; i++) begin
            step(1'b1, longint'(i * 37 - 250), 1'b0, 5, 1, 2, 1'b0);
        end
        idle(4);

        // Clear with a simultaneous valid drops that beat
        step(1'b1, 3, 1'b0);
        step(1'b1, 4, 1'b0);
        step(1'b1, 9, 1'b1);
        group(1, 1, 1, 1, 0, 1, 0, 1'b0);          // 4
        idle(4);

        // Reset while an output is in flight
        group(7, 7, 7, 7, 0, 1, 0, 1'b0);
        step(1'b1, 7, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        pidx = 0;
        psum = 0;
        #1;
        check("midreset_o_valid", o_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midreset_o_valid_held", o_valid, 0);
        rst_n = 1'b1;
        group(2, 2, 2, 2, 0, 1, 0, 1'b0);          // 8
        idle(4);

        // Randomised traffic with gaps and occasional clears
        for (int i = 0; i < 600; i++) begin
            bit     v, clr, relu;
            longint d;
            int     bias, scale, shift;
            v     = ($urandom % 4) != 0;
            clr   = ($urandom % 40) == 0;
            d     = longint'($signed($urandom) >>> (32 - IN_W));
            bias  = int'($urandom_range(0, 65535)) - 32768;
            scale = ($urandom % 3 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 15));
            shift = int'($urandom_range(0, 31));
            relu  = $urandom % 2;
            step(v, d, clr, bias, scale, shift, relu);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(2);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
